alu_mc: RTL and testbench



---
 rtl/alu_mc.sv | 210 +++++++++++++++++++++
 tb/tb_alu_mc.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the MIPS EX stage: registered results, valid/ready on both sides,
// iterative shifts and shift-add multiply. Define ALU_OVF_STICKY_EN to add ovf_sticky/ovf_clr.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             set,
  output logic             overflow
`ifdef ALU_OVF_STICKY_EN
  ,
  output logic             ovf_sticky,
  input  logic             ovf_clr
`endif
);

  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [3:0]       op_reg, op_next;
  logic             zero_reg, zero_next;
  logic             set_reg, set_next;
  logic             ovf_reg, ovf_next;
  logic             done_entry;

  logic             sub_op;
  logic [WIDTH-1:0] b_eff, low_sum, add_res, alu_res, step_res;
  logic [1:0]       top_sum;
  logic             add_ovf, slt_lt, alu_set, alu_ovf;
  logic [SHW-1:0]   shamt;
  logic             is_shift, is_mul, accept;

  assign shamt    = b[SHW-1:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign is_mul   = (op == OP_MUL);
  assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Adder split at the MSB so the carry into and out of the sign bit are both visible.
  always_comb begin
    sub_op  = (op == OP_SUB) || (op == OP_SLT);
    b_eff   = sub_op ? ~b : b;
    low_sum = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, sub_op};
    top_sum = {1'b0, a[WIDTH-1]} + {1'b0, b_eff[WIDTH-1]} + {1'b0, low_sum[WIDTH-1]};
    add_res = {top_sum[0], low_sum[WIDTH-2:0]};
    add_ovf = low_sum[WIDTH-1] ^ top_sum[1];
    // Differing signs decide SLT directly, so a wrapped difference never misleads it.
    slt_lt  = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : add_res[WIDTH-1];

    alu_res = '0;
    alu_set = 1'b0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD, OP_SUB: begin
        alu_res = add_res;
        alu_ovf = add_ovf;
      end
      OP_SLT: begin
        alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
        alu_set = slt_lt;
      end
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;  // only reached with a zero shift amount
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (op_reg)
      OP_SLL:  step_res = {acc_reg[WIDTH-2:0], 1'b0};
      OP_SRL:  step_res = {1'b0, acc_reg[WIDTH-1:1]};
      OP_SRA:  step_res = {acc_reg[WIDTH-1], acc_reg[WIDTH-1:1]};
      default: step_res = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    set_next    = set_reg;
    ovf_next    = ovf_reg;
    done_entry  = 1'b0;
    case (state_reg)
      BUSY: begin
        cnt_next    = cnt_reg - CW'(1);
        acc_next    = step_res;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        if (cnt_reg == CW'(1)) begin
          result_next = step_res;
          zero_next   = (step_res == '0);
          set_next    = 1'b0;
          ovf_next    = 1'b0;
          state_next  = DONE;
          done_entry  = 1'b1;
        end
      end
      default: begin
        if ((state_reg == DONE) && out_ready) state_next = IDLE;
        if (accept) begin
          op_next = op;
          if (is_mul) begin
            acc_next    = '0;
            mcand_next  = a;
            mplier_next = b;
            cnt_next    = CW'(WIDTH);
            state_next  = BUSY;
          end else if (is_shift && (shamt != '0)) begin
            acc_next   = a;
            cnt_next   = {1'b0, shamt};
            state_next = BUSY;
          end else begin
            result_next = alu_res;
            zero_next   = (alu_res == '0);
            set_next    = alu_set;
            ovf_next    = alu_ovf;
            state_next  = DONE;
            done_entry  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      set_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      set_reg    <= set_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign set       = set_reg;
  assign overflow  = ovf_reg;

`ifdef ALU_OVF_STICKY_EN
  logic sticky_reg;

  // A completion with overflow wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_reg <= 1'b0;
    else if (done_entry && ovf_next) sticky_reg <= 1'b1;
    else if (ovf_clr) sticky_reg <= 1'b0;
  end

  assign ovf_sticky = sticky_reg;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: reference model of results and latencies checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic         zero, set, overflow;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .set(set), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         s;
    logic         o;
  } exp_t;

  function automatic exp_t ref_alu(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint t;
    int     sh;
    e  = '0;
    sh = int'(y[4:0]);
    case (f)
      4'b0000: e.r = x & y;
      4'b0001: e.r = x | y;
      4'b1100: e.r = ~(x | y);
      4'b0010: begin
        e.r = x + y;
        t   = longint'($signed(x)) + longint'($signed(y));
        e.o = (t != longint'($signed(e.r)));
      end
      4'b0110: begin
        e.r = x - y;
        t   = longint'($signed(x)) - longint'($signed(y));
        e.o = (t != longint'($signed(e.r)));
      end
      4'b0111: begin
        e.s = ($signed(x) < $signed(y));
        e.r = W'(e.s);
      end
      4'b1000: e.r = x << sh;
      4'b1001: e.r = x >> sh;
      4'b1010: e.r = W'($signed(x) >>> sh);
      4'b1011: e.r = W'(longint'(x) * longint'(y));
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  function automatic int ref_lat(input logic [3:0] f, input logic [W-1:0] y);
    if (f == 4'b1000 || f == 4'b1001 || f == 4'b1010) return int'(y[4:0]) + 1;
    if (f == 4'b1011) return W + 1;
    return 1;
  endfunction

  // Model: one outstanding operation, due a fixed number of edges after acceptance.
  logic m_pend;
  int   m_due, cyc;
  exp_t m_exp;
  logic m_valid, m_ready;
  assign m_valid = m_pend && (cyc >= m_due);
  assign m_ready = !m_pend || (m_valid && out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_due  <= 0;
      cyc    <= 0;
      m_exp  <= '0;
    end else begin
      cyc <= cyc + 1;
      if (in_valid && m_ready) begin
        m_pend <= 1'b1;
        m_due  <= cyc + ref_lat(op, b);
        m_exp  <= ref_alu(op, a, b);
      end else if (m_valid && out_ready) begin
        m_pend <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b1);
    end else begin
      chk1("out_valid", out_valid, m_valid);
      chk1("in_ready", in_ready, m_ready);
      if (m_valid && out_valid) begin
        chk("result", result, m_exp.r);
        chk1("zero", zero, m_exp.z);
        chk1("set", set, m_exp.s);
        chk1("overflow", overflow, m_exp.o);
        if (out_ready)
          $display("txn result=%h zero=%b set=%b ovf=%b t=%0t", result, zero, set, overflow, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    op       = f;
    a        = x;
    b        = y;
  endtask

  // Returns at accept edge + 2 with in_valid dropped.
  task automatic issue(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    drive(f, x, y);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk1("accept_wait", in_ready, 1'b1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  // Called at accept edge + 2; lat counts edges from acceptance to visible out_valid.
  task automatic wait_out(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk1("out_wait", out_valid, 1'b1);
  endtask

  typedef struct {
    logic [3:0]   f;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] r;
    int           lat;
  } vec_t;

  vec_t vecs[10] = '{
    '{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1},
    '{4'b0001, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1},
    '{4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1},
    '{4'b1000, 32'h00000003, 32'h0000001F, 32'h80000000, 32},
    '{4'b1001, 32'h80000000, 32'h00000108, 32'h00800000, 9},
    '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1},
    '{4'b0011, 32'h00000005, 32'h00000005, 32'h00000000, 1},
    '{4'b0111, 32'h00000005, 32'hFFFFFFFF, 32'h00000000, 1},
    '{4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33},
    '{4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1}
  };

  initial begin
    int lat;
    int l2;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'b0000;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", result, 32'h0);
    chk1("reset_zero", zero, 1'b0);
    chk1("reset_set", set, 1'b0);
    chk1("reset_ovf", overflow, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // ADD overflow into the sign bit
    issue(4'b0010, 32'h7FFFFFFF, 32'h1);
    wait_out(lat);
    chk("add_lat", W'(lat), 32'd1);
    chk("add_res", result, 32'h80000000);
    chk1("add_ovf", overflow, 1'b1);
    chk1("add_zero", zero, 1'b0);
    step();

    // SUB then SLT back to back
    drive(4'b0110, 32'd5, 32'd5);
    @(negedge clk);
    chk1("b2b_ready0", in_ready, 1'b1);
    step();
    drive(4'b0111, 32'h80000000, 32'h1);
    @(negedge clk);
    chk1("sub_valid", out_valid, 1'b1);
    chk("sub_res", result, 32'h0);
    chk1("sub_zero", zero, 1'b1);
    chk1("b2b_ready1", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk1("slt_valid", out_valid, 1'b1);
    chk("slt_res", result, 32'h1);
    chk1("slt_set", set, 1'b1);
    chk1("slt_ovf", overflow, 1'b0);
    step();

    // SRA by 4 and by 0
    issue(4'b1010, 32'hF0000000, 32'd4);
    wait_out(lat);
    chk("sra4_lat", W'(lat), 32'd5);
    chk("sra4_res", result, 32'hFF000000);
    step();
    issue(4'b1010, 32'hF0000000, 32'd0);
    wait_out(lat);
    chk("sra0_lat", W'(lat), 32'd1);
    chk("sra0_res", result, 32'hF0000000);
    step();

    // MUL with operand churn and in_valid held during BUSY
    drive(4'b1011, 32'h00010003, 32'h00000005);
    @(negedge clk);
    step();
    drive(4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk1("mul_busy_ready", in_ready, 1'b0);
      step();
      a = a - 32'd7;
      b = b ^ 32'h5A5A5A5A;
    end
    in_valid = 1'b0;
    wait_out(l2);
    chk("mul_lat", W'(20 + l2), 32'd33);
    chk("mul_res", result, 32'h0005000F);
    step();

    // Backpressure for 10 cycles
    out_ready = 1'b0;
    issue(4'b0110, 32'h80000000, 32'h1);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      chk1("bp_valid", out_valid, 1'b1);
      chk1("bp_ready", in_ready, 1'b0);
      chk("bp_res", result, 32'h7FFFFFFF);
      chk1("bp_ovf", overflow, 1'b1);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk1("bp_release_ready", in_ready, 1'b1);
    step();
    @(negedge clk);
    chk1("bp_idle_valid", out_valid, 1'b0);
    step();

    // Directed vector table
    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].x, vecs[i].y);
      wait_out(lat);
      chk("vec_lat", W'(lat), W'(vecs[i].lat));
      chk("vec_res", result, vecs[i].r);
      step();
    end

    // Reset in the middle of a multiply
    drive(4'b1011, 32'h00001234, 32'h00000010);
    @(negedge clk);
    step();
    in_valid = 1'b0;
    repeat (11) step();
    rst_n = 1'b0;
    #1;
    chk1("midrst_valid", out_valid, 1'b0);
    chk("midrst_res", result, 32'h0);
    chk1("midrst_ready", in_ready, 1'b1);
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post_rst_ready", in_ready, 1'b1);
    step();
    issue(4'b0010, 32'd2, 32'd3);
    wait_out(lat);
    chk("post_rst_lat", W'(lat), 32'd1);
    chk("post_rst_add", result, 32'd5);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
